// File: rtl/axis_upsize.sv
// AXI-Stream narrow-to-wide packer: gathers RATIO WIDTH-bit beats into one OUTW-bit word,
// flushing a short group on s_tlast with m_tkeep marking the valid lanes.
module axis_upsize #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [WIDTH-1:0]       s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [RATIO-1:0]       m_tkeep,
    output logic [WIDTH*RATIO-1:0] m_tdata
);
    localparam int unsigned OUTW = WIDTH * RATIO;
    localparam int unsigned IDXW = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int unsigned ACCW = (RATIO > 1) ? WIDTH * (RATIO - 1) : WIDTH;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(RATIO - 1);

    if (RATIO < 2) begin : g_ratio_check
        $error("axis_upsize: RATIO must be >= 2");
    end

    logic [IDXW-1:0] idx;
    logic [ACCW-1:0] acc;
    logic [OUTW-1:0] word_d;
    logic [RATIO-1:0] keep_d;
    logic accept;
    logic complete;

    // Ready depends only on output-register state, never on s_tvalid/s_tlast.
    assign s_tready = ~areset & (~m_tvalid | m_tready);
    assign accept   = s_tvalid & s_tready;
    assign complete = accept & (s_tlast | (idx == LastIdx));

    always_comb begin
        word_d = '0;
        keep_d = '0;
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            if (i < int'(idx)) begin
                word_d[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < int'(RATIO); i++) begin
            if (i == int'(idx)) begin
                word_d[i*WIDTH +: WIDTH] = s_tdata;
            end
            keep_d[i] = (i <= int'(idx));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx      <= '0;
            acc      <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
        end else if (complete) begin
            // A completing beat may coincide with the downstream transfer; reload in place.
            idx      <= '0;
            acc      <= '0;
            m_tvalid <= 1'b1;
            m_tlast  <= s_tlast;
            m_tkeep  <= keep_d;
            m_tdata  <= word_d;
        end else begin
            if (accept) begin
                for (int i = 0; i < int'(RATIO) - 1; i++) begin
                    if (idx == IDXW'(i)) begin
                        acc[i*WIDTH +: WIDTH] <= s_tdata;
                    end
                end
                idx <= idx + IDXW'(1);
            end
            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_upsize.sv
// Randomised and directed bench for axis_upsize (WIDTH=8, RATIO=4) with a queue-based
// packing model and a negedge monitor that scores every output word.
module tb_axis_upsize;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic [31:0] m_tdata;

    int errors = 0;
    int checks = 0;
    int n_words = 0;
    int n_acc = 0;
    int cyc = 0;

    logic [7:0] group[$];
    word_t      exp_q[$];
    bit         exp_valid_next = 0;
    bit         stall_prev = 0;
    word_t      held;

    axis_upsize #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .aclk     (clk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tkeep  (m_tkeep),
        .m_tdata  (m_tdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor + reference model: sampled mid-cycle, handshakes seen here complete at next posedge.
    always @(negedge clk) begin : monitor
        word_t e;
        word_t w;
        if (areset) begin
            group.delete();
            exp_q.delete();
            exp_valid_next = 0;
            stall_prev = 0;
            chk({m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready} == '0, "reset_outputs",
                {m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready}, 0);
        end else begin
            if (exp_valid_next) chk(m_tvalid == 1'b1, "latency_valid", m_tvalid, 1);
            if (stall_prev)
                chk(m_tvalid && m_tdata == held.data && m_tkeep == held.keep &&
                    m_tlast == held.last, "stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata},
                    {1'b1, held.last, held.keep, held.data});
            chk(s_tready == (!m_tvalid || m_tready), "s_tready", s_tready,
                (!m_tvalid || m_tready));
            if (m_tvalid) chk(m_tkeep != 0, "keep_nonzero", m_tkeep, 4'hf);
            if (m_tvalid && m_tready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_word", m_tdata, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk(m_tdata == w.data && m_tkeep == w.keep && m_tlast == w.last, "word",
                        {m_tlast, m_tkeep, m_tdata}, {w.last, w.keep, w.data});
                end
            end
            exp_valid_next = 0;
            if (s_tvalid && s_tready) begin
                n_acc++;
                group.push_back(s_tdata);
                if (s_tlast || group.size() == RATIO) begin
                    e.data = '0;
                    e.keep = '0;
                    foreach (group[k]) begin
                        e.data[k*8 +: 8] = group[k];
                        e.keep[k] = 1'b1;
                    end
                    e.last = s_tlast;
                    exp_q.push_back(e);
                    group.delete();
                    exp_valid_next = 1;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held.data = m_tdata;
            held.keep = m_tkeep;
            held.last = m_tlast;
        end
    end

    task automatic send(input logic [7:0] d, input bit last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_tready) break;
            if (t > 200) begin
                chk(0, "send_timeout", t, 200);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        m_tready = 1'b1;
        for (int t = 0; t < 50 && (exp_q.size() != 0 || m_tvalid); t++) begin
            @(posedge clk);
            #1;
        end
        chk(exp_q.size() == 0 && !m_tvalid, name, exp_q.size(), 0);
    endtask

    initial begin : stim
        int w0;
        int c0;
        int a0;
        bit acc_prev;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        m_tready = 1'b1;

        // Two full words, the second ending the packet
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        drain("drain_t1");

        // Short group then full group
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
        for (int i = 1; i <= 4; i++) send(8'hB0 + 8'(i), i == 4);
        drain("drain_t2");

        // Single-beat packet: valid must be up right after acceptance
        send(8'h5C, 1);
        chk(m_tvalid && m_tdata == 32'h5C && m_tkeep == 4'h1 && m_tlast, "single_beat",
            {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b1, 4'h1, 32'h5C});
        drain("drain_t3");

        // Back-pressure with a word pending
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'h40 + 8'(i), 0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk(s_tready == 1'b0, "stall_ready", s_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        send(8'h55, 0); send(8'h56, 0); send(8'h57, 0); send(8'h58, 1);
        drain("drain_t4");

        // Reset in the middle of a group
        w0 = n_words;
        send(8'h11, 0); send(8'h22, 0);
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h33 + 8'(i), i == 3);
        drain("drain_t5");
        chk(n_words - w0 == 1, "reset_word_count", n_words - w0, 1);

        // Throughput: continuous valid/ready, 40 beats in 40 cycles, 10 words
        w0 = n_words;
        c0 = cyc;
        for (int i = 0; i < 40; i++) send(8'(i * 3), 0);
        chk(cyc - c0 == 40, "throughput_cycles", cyc - c0, 40);
        drain("drain_tp");
        chk(n_words - w0 == 10, "throughput_words", n_words - w0, 10);

        // Random traffic
        a0 = n_acc;
        acc_prev = 0;
        for (int t = 0; t < 20000 && n_acc - a0 < 1000; t++) begin
            @(negedge clk);
            acc_prev = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (!s_tvalid || acc_prev) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = 8'($urandom);
                s_tlast  = ($urandom_range(0, 5) == 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
        end
        chk(n_acc - a0 >= 1000, "random_beats", n_acc - a0, 1000);
        m_tready = 1'b1;
        send(8'hEE, 1);
        drain("drain_rand");
        chk(group.size() == 0, "group_empty", group.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
